adsr_envelope_sequencer: RTL and testbench

//   Sequences the ADSR envelope for one synth voice: a 5-state FSM (IDLE/ATTACK/DECAY/SUSTAIN/RELEASE)

---
 rtl/adsr_envelope_sequencer.sv | 165 ++++++++++++++++
 tb/tb_adsr_envelope_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adsr_envelope_sequencer.sv
// ADSR envelope sequencer for one synth voice.
// Five-phase FSM steps the envelope level on a divided timebase strobe; the
// divider period is taken live from the pot setting of the current phase.
// Build option: define ADSR_EXP_RELEASE_EN for an exponential release tail
// (subtract max(level>>4, 1) per step); otherwise the release is linear.
//
//   state     | meaning
//   S_IDLE    | silent, level parked (normally 0), waiting for a gate rise
//   S_ATTACK  | ramping up by STEP per divided tick until MAX_LEVEL
//   S_DECAY   | ramping down by STEP until sustain_level is reached
//   S_SUSTAIN | level follows sustain_level while the gate is held
//   S_RELEASE | ramping down to 0 after the gate falls
module adsr_envelope_sequencer #(
  parameter int LEVEL_W = 10,
  parameter int TIME_W  = 10,
  parameter int STEP    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick_en,
  input  logic               gate,
  input  logic [TIME_W-1:0]  attack_time,
  input  logic [TIME_W-1:0]  decay_time,
  input  logic [LEVEL_W-1:0] sustain_level,
  input  logic [TIME_W-1:0]  release_time,
  output logic [LEVEL_W-1:0] env_level,
  output logic [2:0]         env_phase,
  output logic               env_valid,
  output logic               busy
);

  localparam int MAX_LEVEL = 2**LEVEL_W - 1;
  localparam logic [LEVEL_W:0] MAX_W  = (LEVEL_W+1)'(MAX_LEVEL);
  localparam logic [LEVEL_W:0] STEP_W = (LEVEL_W+1)'(STEP);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ATTACK  = 3'd1,
    S_DECAY   = 3'd2,
    S_SUSTAIN = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [LEVEL_W-1:0]  level_q, level_d;
  logic                valid_q, valid_d;
  logic [TIME_W-1:0]   div_q, div_d;
  logic                gate_q;

  logic                rise, fall, step;
  logic [TIME_W-1:0]   cur_time;
  logic [LEVEL_W:0]    level_ext, sus_ext, sum_ext, dec_ext;

  // Edge detect, live time select and the widened arithmetic operands.
  always_comb begin
    rise      = gate & ~gate_q;
    fall      = ~gate & gate_q;
    level_ext = {1'b0, level_q};
    sus_ext   = {1'b0, sustain_level};
    sum_ext   = level_ext + STEP_W;
    cur_time  = '0;
    case (state_q)
      S_ATTACK:  cur_time = attack_time;
      S_DECAY:   cur_time = decay_time;
      S_RELEASE: cur_time = release_time;
      default:   cur_time = '0;
    endcase
    step = tick_en & (div_q >= cur_time);
`ifdef ADSR_EXP_RELEASE_EN
    dec_ext = level_ext >> 4;
    if (dec_ext == '0) dec_ext = (LEVEL_W+1)'(1);
`else
    dec_ext = STEP_W;
`endif
  end

  // Next-state, level and divider logic; rise beats fall beats stepping.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    div_d   = div_q;
    if (rise) begin
      state_d = S_ATTACK;
      div_d   = '0;
    end else if (fall && (state_q == S_ATTACK || state_q == S_DECAY ||
                          state_q == S_SUSTAIN)) begin
      state_d = S_RELEASE;
      div_d   = '0;
    end else begin
      case (state_q)
        S_ATTACK: begin
          if (step) begin
            div_d = '0;
            if (sum_ext >= MAX_W) begin
              level_d = LEVEL_W'(MAX_LEVEL);
              state_d = S_DECAY;
            end else begin
              level_d = LEVEL_W'(sum_ext);
            end
          end else if (tick_en) begin
            div_d = div_q + TIME_W'(1);
          end
        end
        S_DECAY: begin
          if (step) begin
            div_d = '0;
            // level - STEP <= sustain, rearranged so nothing underflows
            if (level_ext <= sus_ext + STEP_W) begin
              level_d = sustain_level;
              state_d = S_SUSTAIN;
            end else begin
              level_d = LEVEL_W'(level_ext - STEP_W);
            end
          end else if (tick_en) begin
            div_d = div_q + TIME_W'(1);
          end
        end
        S_SUSTAIN: begin
          level_d = sustain_level;
          div_d   = '0;
        end
        S_RELEASE: begin
          if (step) begin
            div_d = '0;
            if (level_ext <= dec_ext) begin
              level_d = '0;
              state_d = S_IDLE;
            end else begin
              level_d = LEVEL_W'(level_ext - dec_ext);
            end
          end else if (tick_en) begin
            div_d = div_q + TIME_W'(1);
          end
        end
        default: begin
          div_d = '0;
        end
      endcase
    end
    valid_d = (level_d != level_q);
  end

  // State, level, divider and gate history registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      level_q <= '0;
      valid_q <= 1'b0;
      div_q   <= '0;
      gate_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      valid_q <= valid_d;
      div_q   <= div_d;
      gate_q  <= gate;
    end
  end

  assign env_level = level_q;
  assign env_phase = state_q;
  assign env_valid = valid_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_adsr_envelope_sequencer.sv
// Bench for adsr_envelope_sequencer: per-cycle reference model feeding a
// scoreboard queue, a table of directed checkpoints, and hand sequences for
// retrigger, sustain-at-max, release shape and asynchronous reset.
module tb_adsr_envelope_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_en = 1'b0;
  logic       gate = 1'b0;
  logic [9:0] attack_time = '0;
  logic [9:0] decay_time = '0;
  logic [9:0] sustain_level = '0;
  logic [9:0] release_time = '0;
  logic [9:0] env_level;
  logic [2:0] env_phase;
  logic       env_valid;
  logic       busy;

  adsr_envelope_sequencer #(.LEVEL_W(10), .TIME_W(10), .STEP(8)) dut (
    .clk(clk), .rst(rst), .tick_en(tick_en), .gate(gate),
    .attack_time(attack_time), .decay_time(decay_time),
    .sustain_level(sustain_level), .release_time(release_time),
    .env_level(env_level), .env_phase(env_phase),
    .env_valid(env_valid), .busy(busy)
  );

  always #5 clk = ~clk;

`ifdef ADSR_EXP_RELEASE_EN
  localparam int E_R1 = 960;
  localparam int E_R2 = 900;
  localparam int E_RB = 23;
`else
  localparam int E_R1 = 1015;
  localparam int E_R2 = 1007;
  localparam int E_RB = 16;
`endif

  typedef struct {
    int level;
    int phase;
    int valid;
  } exp_t;

  typedef struct {
    logic gate;
    logic tick;
    int   a, d, s, r;
    int   cycles;
    int   exp_level;
    int   exp_phase;
    bit   rel;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[18];

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_level = 0, m_phase = 0, m_div = 0, m_gate = 0;

  task automatic check(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, want, $time);
    end
  endtask

  task automatic model_next(output exp_t e, output int nd);
    int ct, nl, np, dec;
    bit rise, fall, stp;
    rise = (gate == 1'b1) && (m_gate == 0);
    fall = (gate == 1'b0) && (m_gate == 1);
    ct = (m_phase == 1) ? int'(attack_time) :
         (m_phase == 2) ? int'(decay_time) :
         (m_phase == 4) ? int'(release_time) : 0;
    stp = (tick_en == 1'b1) && (m_div >= ct);
    nl = m_level; np = m_phase; nd = m_div;
    if (rise) begin
      np = 1; nd = 0;
    end else if (fall && m_phase >= 1 && m_phase <= 3) begin
      np = 4; nd = 0;
    end else if (m_phase == 3) begin
      nl = int'(sustain_level); nd = 0;
    end else if (m_phase == 0) begin
      nd = 0;
    end else if (!stp) begin
      if (tick_en) nd = m_div + 1;
    end else begin
      nd = 0;
      if (m_phase == 1) begin
        if (m_level + 8 >= 1023) begin nl = 1023; np = 2; end
        else nl = m_level + 8;
      end else if (m_phase == 2) begin
        if (m_level - 8 <= int'(sustain_level)) begin nl = int'(sustain_level); np = 3; end
        else nl = m_level - 8;
      end else begin
`ifdef ADSR_EXP_RELEASE_EN
        dec = (m_level / 16 < 1) ? 1 : m_level / 16;
`else
        dec = 8;
`endif
        if (m_level - dec <= 0) begin nl = 0; np = 0; end
        else nl = m_level - dec;
      end
    end
    e.level = nl;
    e.phase = np;
    e.valid = (nl != m_level) ? 1 : 0;
  endtask

  // one clock: predict, push, clock, pop and compare
  task automatic cyc();
    exp_t e, g;
    int nd;
    model_next(e, nd);
    sb_q.push_back(e);
    @(posedge clk); #1;
    g = sb_q.pop_front();
    check("sb_level", int'(env_level), g.level);
    check("sb_phase", int'(env_phase), g.phase);
    check("sb_valid", int'(env_valid), g.valid);
    check("sb_busy", int'(busy), (g.phase != 0) ? 1 : 0);
    m_level = g.level; m_phase = g.phase; m_div = nd; m_gate = int'(gate);
  endtask

  task automatic check_reset_outs(input string nm);
    check({nm, "_level"}, int'(env_level), 0);
    check({nm, "_phase"}, int'(env_phase), 0);
    check({nm, "_valid"}, int'(env_valid), 0);
    check({nm, "_busy"}, int'(busy), 0);
  endtask

  task automatic do_reset();
    tick_en = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_outs("rst_hold");
    rst = 1'b0;
    m_level = 0; m_phase = 0; m_div = 0; m_gate = 0;
    sb_q.delete();
  endtask

  initial begin
    bit chk_row;
    vecs[0]  = '{1'b0, 1'b1, 0, 3, 500, 1,   3,    0, 0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 0, 3, 500, 1,   1,    0, 1, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 0, 3, 500, 1, 127, 1016, 1, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 0, 3, 500, 1,   1, 1023, 2, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 0, 3, 500, 1,   4, 1015, 2, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 0, 3, 500, 1, 260,  500, 3, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 0, 3, 508, 1,   1,  508, 3, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 0, 3, 508, 1,   1,  508, 4, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 0, 3, 508, 1,   2,  500, 4, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 0, 3, 508, 1,  10,  500, 4, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 0, 3, 508, 1,  50,  300, 4, 1'b1};
    vecs[11] = '{1'b1, 1'b1, 0, 3, 508, 1,   1,  300, 1, 1'b1};
    vecs[12] = '{1'b1, 1'b1, 0, 3, 508, 1,   1,  308, 1, 1'b1};
    vecs[13] = '{1'b1, 1'b1, 5, 3, 508, 1,   5,  308, 1, 1'b1};
    vecs[14] = '{1'b1, 1'b1, 5, 3, 508, 1,   1,  316, 1, 1'b1};
    vecs[15] = '{1'b0, 1'b1, 5, 3, 508, 0,   1,  316, 4, 1'b1};
    vecs[16] = '{1'b0, 1'b1, 5, 3, 508, 0,  39,    4, 4, 1'b1};
    vecs[17] = '{1'b0, 1'b1, 5, 3, 508, 0,   1,    0, 0, 1'b1};

    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // directed table
    for (int i = 0; i < 18; i++) begin
      gate          = vecs[i].gate;
      tick_en       = vecs[i].tick;
      attack_time   = 10'(vecs[i].a);
      decay_time    = 10'(vecs[i].d);
      sustain_level = 10'(vecs[i].s);
      release_time  = 10'(vecs[i].r);
      for (int c = 0; c < vecs[i].cycles; c++) cyc();
      chk_row = 1'b1;
`ifdef ADSR_EXP_RELEASE_EN
      chk_row = !vecs[i].rel;
`endif
      if (chk_row) begin
        check($sformatf("row%0d_level", i), int'(env_level), vecs[i].exp_level);
        check($sformatf("row%0d_phase", i), int'(env_phase), vecs[i].exp_phase);
      end
    end

    // full attack, sustain at MAX_LEVEL, then release shape to IDLE
    gate = 1'b0; tick_en = 1'b1; cyc(); cyc();
    sustain_level = 10'd1023; decay_time = '0; attack_time = '0; release_time = '0;
    gate = 1'b1;
    for (int c = 0; c < 129; c++) cyc();
    check("max_level", int'(env_level), 1023);
    check("max_phase", int'(env_phase), 2);
    cyc();
    check("susmax_level", int'(env_level), 1023);
    check("susmax_phase", int'(env_phase), 3);
    check("susmax_valid", int'(env_valid), 0);
    gate = 1'b0;
    cyc();
    check("rel_enter_phase", int'(env_phase), 4);
    check("rel_enter_level", int'(env_level), 1023);
    cyc();
    check("rel_step1", int'(env_level), E_R1);
    cyc();
    check("rel_step2", int'(env_level), E_R2);
    for (int k = 0; k < 2000 && env_phase != 3'd0; k++) cyc();
    check("rel_idle_phase", int'(env_phase), 0);
    check("rel_idle_level", int'(env_level), 0);
    check("rel_idle_busy", int'(busy), 0);

    // rise coinciding with a release step: rise wins, level held
    gate = 1'b1;
    for (int c = 0; c < 4; c++) cyc();
    check("rb_attack_level", int'(env_level), 24);
    gate = 1'b0;
    cyc();
    check("rb_rel_phase", int'(env_phase), 4);
    cyc();
    check("rb_rel_level", int'(env_level), E_RB);
    gate = 1'b1;
    cyc();
    check("rb_rise_level", int'(env_level), E_RB);
    check("rb_rise_phase", int'(env_phase), 1);
    check("rb_rise_valid", int'(env_valid), 0);

    // asynchronous reset mid-attack at level 200, tick_en held high
    do_reset();
    gate = 1'b1; attack_time = '0;
    for (int c = 0; c < 26; c++) cyc();
    check("pre_rst_level", int'(env_level), 200);
    check("pre_rst_phase", int'(env_phase), 1);
    rst = 1'b1;
    #2;
    check_reset_outs("rst_async");
    @(posedge clk); #1;
    check_reset_outs("rst_tick");
    rst = 1'b0;
    m_level = 0; m_phase = 0; m_div = 0; m_gate = 0;
    cyc();
    check("post_rst_phase", int'(env_phase), 1);
    cyc();
    check("post_rst_level", int'(env_level), 8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
